// File: rtl/mem_access_pkg.sv
// Shared widths, load/store op codes, reset values and FSM states for the MEM stage.
package mem_access_pkg;

  localparam int REG_BUS      = 32;
  localparam int REG_ADDR_BUS = 5;
  localparam int ALU_OP_BUS   = 8;

  localparam logic [ALU_OP_BUS-1:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [ALU_OP_BUS-1:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [ALU_OP_BUS-1:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [ALU_OP_BUS-1:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [ALU_OP_BUS-1:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [ALU_OP_BUS-1:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [ALU_OP_BUS-1:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [ALU_OP_BUS-1:0] EXE_SW_OP  = 8'b1110_1011;

  localparam logic                    WRITE_DISABLE = 1'b0;
  localparam logic [REG_ADDR_BUS-1:0] NOP_REG_ADDR  = '0;
  localparam logic [REG_BUS-1:0]      ZERO_WORD     = '0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mem_access_if.sv
// Data-bus req/ack handshake between the MEM stage (master) and data memory (slave).
interface mem_access_if ();
  import mem_access_pkg::*;

  logic               req;
  logic               we;
  logic [REG_BUS-1:0] addr;
  logic [3:0]         sel;
  logic [REG_BUS-1:0] wdata;
  logic [REG_BUS-1:0] rdata;
  logic               ack;

  modport master (output req, we, addr, sel, wdata, input rdata, ack);
  modport slave  (input req, we, addr, sel, wdata, output rdata, ack);
endinterface

// File: rtl/mem_access_align.sv
// Big-endian lane logic: byte enables, store replication, load extract and extend.
// With MEM_ALIGN_EXC_EN defined it also flags misaligned half/word accesses.
module mem_access_align import mem_access_pkg::*; (
  input  logic [ALU_OP_BUS-1:0] i_aluop,
  input  logic [1:0]            i_addr_lo,
  input  logic [REG_BUS-1:0]    i_reg2,
  input  logic [REG_BUS-1:0]    i_rdata,
  output logic                  o_is_mem,
  output logic                  o_is_store,
`ifdef MEM_ALIGN_EXC_EN
  output logic                  o_misaligned,
`endif
  output logic [3:0]            o_sel,
  output logic [REG_BUS-1:0]    o_store_data,
  output logic [REG_BUS-1:0]    o_load_data
);

  logic [7:0]  w_rbyte [4];
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_mis;

  // Lane 0 is the most significant byte (address offset 0 in big-endian order)
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign w_rbyte[gi] = i_rdata[8*(3-gi) +: 8];
    end
  endgenerate

  assign w_byte = w_rbyte[i_addr_lo];
  assign w_half = i_addr_lo[1] ? i_rdata[15:0] : i_rdata[31:16];

  always_comb begin
    o_is_mem     = 1'b0;
    o_is_store   = 1'b0;
    w_mis        = 1'b0;
    o_sel        = 4'b0000;
    o_store_data = ZERO_WORD;
    o_load_data  = ZERO_WORD;
    case (i_aluop)
      EXE_LB_OP, EXE_LBU_OP: begin
        o_is_mem    = 1'b1;
        o_sel       = 4'b1000 >> i_addr_lo;
        o_load_data = {{24{w_byte[7] & (i_aluop == EXE_LB_OP)}}, w_byte};
      end
      EXE_LH_OP, EXE_LHU_OP: begin
        o_is_mem    = 1'b1;
        w_mis       = i_addr_lo[0];
        o_sel       = i_addr_lo[1] ? 4'b0011 : 4'b1100;
        o_load_data = {{16{w_half[15] & (i_aluop == EXE_LH_OP)}}, w_half};
      end
      EXE_LW_OP: begin
        o_is_mem    = 1'b1;
        w_mis       = |i_addr_lo;
        o_sel       = 4'b1111;
        o_load_data = i_rdata;
      end
      EXE_SB_OP: begin
        o_is_mem     = 1'b1;
        o_is_store   = 1'b1;
        o_sel        = 4'b1000 >> i_addr_lo;
        o_store_data = {4{i_reg2[7:0]}};
      end
      EXE_SH_OP: begin
        o_is_mem     = 1'b1;
        o_is_store   = 1'b1;
        w_mis        = i_addr_lo[0];
        o_sel        = i_addr_lo[1] ? 4'b0011 : 4'b1100;
        o_store_data = {2{i_reg2[15:0]}};
      end
      EXE_SW_OP: begin
        o_is_mem     = 1'b1;
        o_is_store   = 1'b1;
        w_mis        = |i_addr_lo;
        o_sel        = 4'b1111;
        o_store_data = i_reg2;
      end
      default: ;
    endcase
  end

`ifdef MEM_ALIGN_EXC_EN
  assign o_misaligned = w_mis;
`else
  // Misaligned half/word accesses are simply truncated to their natural boundary
  logic w_unused_mis;
  assign w_unused_mis = w_mis;
`endif

endmodule

// File: rtl/mem_access.sv
// MEM pipeline stage: ALU passthrough plus a stalling req/ack data-bus access for loads/stores.
// Optional MEM_ALIGN_EXC_EN adds misaligned-address exception outputs instead of truncation.
module mem_access import mem_access_pkg::*; (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [REG_ADDR_BUS-1:0] i_wd,
  input  logic                    i_wreg,
  input  logic [REG_BUS-1:0]      i_wdata,
  input  logic [ALU_OP_BUS-1:0]   i_aluop,
  input  logic [REG_BUS-1:0]      i_mem_addr,
  input  logic [REG_BUS-1:0]      i_reg2,
  output logic [REG_ADDR_BUS-1:0] o_wd,
  output logic                    o_wreg,
  output logic [REG_BUS-1:0]      o_wdata,
  output logic                    o_stall_req,
`ifdef MEM_ALIGN_EXC_EN
  output logic                    o_excp_adel,
  output logic                    o_excp_ades,
`endif
  mem_access_if.master            dbus
);

  state_t             r_state;
  logic [REG_BUS-1:0] r_rdata;

  logic               w_is_mem;
  logic               w_is_store;
  logic               w_misaligned;
  logic               w_access;
  logic [3:0]         w_sel;
  logic [REG_BUS-1:0] w_store_data;
  logic [REG_BUS-1:0] w_load_data;

  mem_access_align u_align (
    .i_aluop      (i_aluop),
    .i_addr_lo    (i_mem_addr[1:0]),
    .i_reg2       (i_reg2),
    .i_rdata      (r_rdata),
    .o_is_mem     (w_is_mem),
    .o_is_store   (w_is_store),
`ifdef MEM_ALIGN_EXC_EN
    .o_misaligned (w_misaligned),
`endif
    .o_sel        (w_sel),
    .o_store_data (w_store_data),
    .o_load_data  (w_load_data)
  );

`ifdef MEM_ALIGN_EXC_EN
  assign o_excp_adel = ~rst & w_is_mem & ~w_is_store & w_misaligned;
  assign o_excp_ades = ~rst & w_is_mem &  w_is_store & w_misaligned;
`else
  assign w_misaligned = 1'b0;
`endif

  assign w_access = w_is_mem & ~w_misaligned;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_rdata <= ZERO_WORD;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_access) begin
            if (dbus.ack) begin
              r_state <= ST_DONE;
              r_rdata <= dbus.rdata;
            end else begin
              r_state <= ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          if (dbus.ack) begin
            r_state <= ST_DONE;
            r_rdata <= dbus.rdata;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Reset gates every output combinationally so a request in flight drops immediately
  always_comb begin
    o_wd        = NOP_REG_ADDR;
    o_wreg      = WRITE_DISABLE;
    o_wdata     = ZERO_WORD;
    o_stall_req = 1'b0;
    dbus.req    = 1'b0;
    dbus.we     = 1'b0;
    dbus.addr   = ZERO_WORD;
    dbus.sel    = 4'b0000;
    dbus.wdata  = ZERO_WORD;
    if (!rst) begin
      o_wd    = i_wd;
      o_wreg  = i_wreg;
      o_wdata = i_wdata;
      if (w_access) begin
        dbus.req    = (r_state != ST_DONE);
        dbus.we     = w_is_store;
        dbus.addr   = {i_mem_addr[REG_BUS-1:2], 2'b00};
        dbus.sel    = w_sel;
        dbus.wdata  = w_store_data;
        o_stall_req = (r_state != ST_DONE);
        if (w_is_store) begin
          o_wreg = WRITE_DISABLE;
        end else begin
          o_wreg  = i_wreg & (r_state == ST_DONE);
          o_wdata = w_load_data;
        end
      end else if (w_is_mem) begin
        o_wreg = WRITE_DISABLE;
      end
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: passthrough, load/store lanes, wait states and mid-access reset.
module tb_mem_access;
  import mem_access_pkg::*;

  localparam logic [7:0] ADD_OP = 8'b0010_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  i_wd = '0;
  logic        i_wreg = 1'b0;
  logic [31:0] i_wdata = '0;
  logic [7:0]  i_aluop = '0;
  logic [31:0] i_mem_addr = '0;
  logic [31:0] i_reg2 = '0;
  logic [4:0]  o_wd;
  logic        o_wreg;
  logic [31:0] o_wdata;
  logic        o_stall_req;
`ifdef MEM_ALIGN_EXC_EN
  logic        o_excp_adel;
  logic        o_excp_ades;
`endif

  mem_access_if dbus ();

  mem_access dut (
    .clk         (clk),
    .rst         (rst),
    .i_wd        (i_wd),
    .i_wreg      (i_wreg),
    .i_wdata     (i_wdata),
    .i_aluop     (i_aluop),
    .i_mem_addr  (i_mem_addr),
    .i_reg2      (i_reg2),
    .o_wd        (o_wd),
    .o_wreg      (o_wreg),
    .o_wdata     (o_wdata),
    .o_stall_req (o_stall_req),
`ifdef MEM_ALIGN_EXC_EN
    .o_excp_adel (o_excp_adel),
    .o_excp_ades (o_excp_ades),
`endif
    .dbus        (dbus.master)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  logic [3:0]  c_sel;
  logic        c_we;
  logic [31:0] c_addr;
  logic [31:0] c_bus_wdata;
  logic [31:0] c_res;
  logic        c_wreg;
  logic        c_req_done;
  logic        c_stable;
  int          c_stall;

  // Drives one load/store, acking after 'waits' request cycles; returns at the negedge of the result cycle
  task automatic run_mem(input string name, input logic [7:0] op, input logic [31:0] addr,
                         input logic [31:0] reg2, input logic [31:0] rdata, input int waits);
    i_aluop     = op;
    i_mem_addr  = addr;
    i_reg2      = reg2;
    i_wreg      = 1'b1;
    i_wd        = 5'd9;
    i_wdata     = 32'h0BAD0BAD;
    c_stall     = 0;
    c_stable    = 1'b1;
    c_sel       = '0;
    c_we        = 1'b0;
    c_addr      = '0;
    c_bus_wdata = '0;
    c_res       = '0;
    c_wreg      = 1'b0;
    c_req_done  = 1'b0;
    for (int cyc = 0; cyc < 64; cyc++) begin
      dbus.ack   = (cyc == waits);
      dbus.rdata = (cyc == waits) ? rdata : 32'hDEADBEEF;
      @(negedge clk);
      if (!o_stall_req) begin
        c_res      = o_wdata;
        c_wreg     = o_wreg;
        c_req_done = dbus.req;
        break;
      end
      if (cyc == 0) begin
        c_sel       = dbus.sel;
        c_we        = dbus.we;
        c_addr      = dbus.addr;
        c_bus_wdata = dbus.wdata;
      end else if (dbus.sel !== c_sel || dbus.we !== c_we || dbus.addr !== c_addr ||
                   dbus.wdata !== c_bus_wdata || dbus.req !== 1'b1) begin
        c_stable = 1'b0;
      end
      c_stall++;
      next_cyc();
    end
    dbus.ack = 1'b0;
    $display("txn %s addr=%h stall=%0d sel=%b we=%b bus_addr=%h bus_wdata=%h result=%h wreg=%b",
             name, addr, c_stall, c_sel, c_we, c_addr, c_bus_wdata, c_res, c_wreg);
  endtask

  initial begin
    dbus.ack   = 1'b0;
    dbus.rdata = '0;
    // Reset with a load presented: every output must stay cleared
    rst        = 1'b1;
    i_aluop    = EXE_LW_OP;
    i_mem_addr = 32'h10;
    i_wdata    = 32'h55;
    i_wreg     = 1'b1;
    i_wd       = 5'd3;
    repeat (2) @(posedge clk);
    @(negedge clk);
    $display("txn reset wdata=%h wreg=%b wd=%0d req=%b stall=%b", o_wdata, o_wreg, o_wd, dbus.req, o_stall_req);
    chk("rst_wdata", o_wdata, 32'h0);
    chk("rst_wreg", {31'b0, o_wreg}, 32'h0);
    chk("rst_wd", {27'b0, o_wd}, 32'h0);
    chk("rst_req", {31'b0, dbus.req}, 32'h0);
    chk("rst_stall", {31'b0, o_stall_req}, 32'h0);

    next_cyc();
    rst     = 1'b0;
    i_aluop = ADD_OP;
    i_wdata = 32'h1234;
    i_wreg  = 1'b1;
    i_wd    = 5'd5;
    @(negedge clk);
    $display("txn add wdata=%h wreg=%b wd=%0d req=%b stall=%b", o_wdata, o_wreg, o_wd, dbus.req, o_stall_req);
    chk("add_wdata", o_wdata, 32'h1234);
    chk("add_wreg", {31'b0, o_wreg}, 32'h1);
    chk("add_wd", {27'b0, o_wd}, 32'h5);
    chk("add_req", {31'b0, dbus.req}, 32'h0);
    chk("add_stall", {31'b0, o_stall_req}, 32'h0);

    // Stray ack with no memory op must be ignored
    next_cyc();
    i_wdata  = 32'h77;
    dbus.ack = 1'b1;
    @(negedge clk);
    $display("txn add_ack wdata=%h req=%b stall=%b", o_wdata, dbus.req, o_stall_req);
    chk("idle_ack_stall", {31'b0, o_stall_req}, 32'h0);
    chk("idle_ack_wdata", o_wdata, 32'h77);

    next_cyc();
    run_mem("LB", EXE_LB_OP, 32'h103, 32'h0, 32'h000000F0, 3);
    chk("lb_stall", c_stall, 4);
    chk("lb_sel", {28'b0, c_sel}, 32'b0001);
    chk("lb_we", {31'b0, c_we}, 32'h0);
    chk("lb_addr", c_addr, 32'h100);
    chk("lb_stable", {31'b0, c_stable}, 32'h1);
    chk("lb_result", c_res, 32'hFFFFFFF0);
    chk("lb_wreg", {31'b0, c_wreg}, 32'h1);
    chk("lb_req_done", {31'b0, c_req_done}, 32'h0);

    next_cyc();
    run_mem("SH", EXE_SH_OP, 32'h202, 32'hABCD1234, 32'h0, 0);
    chk("sh_stall", c_stall, 1);
    chk("sh_we", {31'b0, c_we}, 32'h1);
    chk("sh_sel", {28'b0, c_sel}, 32'b0011);
    chk("sh_wdata", c_bus_wdata, 32'h12341234);
    chk("sh_addr", c_addr, 32'h200);
    chk("sh_wreg", {31'b0, c_wreg}, 32'h0);

    next_cyc();
    run_mem("LHU", EXE_LHU_OP, 32'h100, 32'h0, 32'h8001FFFF, 0);
    chk("lhu_sel", {28'b0, c_sel}, 32'b1100);
    chk("lhu_result", c_res, 32'h00008001);

    next_cyc();
    run_mem("LH", EXE_LH_OP, 32'h100, 32'h0, 32'h8001FFFF, 1);
    chk("lh_stall", c_stall, 2);
    chk("lh_result", c_res, 32'hFFFF8001);

    next_cyc();
    run_mem("LBU", EXE_LBU_OP, 32'h101, 32'h0, 32'h11A52233, 1);
    chk("lbu_sel", {28'b0, c_sel}, 32'b0100);
    chk("lbu_result", c_res, 32'h000000A5);

    next_cyc();
    run_mem("SB", EXE_SB_OP, 32'h3, 32'h123456C3, 32'h0, 0);
    chk("sb_sel", {28'b0, c_sel}, 32'b0001);
    chk("sb_wdata", c_bus_wdata, 32'hC3C3C3C3);

    next_cyc();
    run_mem("SW", EXE_SW_OP, 32'h30C, 32'hCAFEF00D, 32'h0, 2);
    chk("sw_stall", c_stall, 3);
    chk("sw_sel", {28'b0, c_sel}, 32'b1111);
    chk("sw_wdata", c_bus_wdata, 32'hCAFEF00D);
    chk("sw_addr", c_addr, 32'h30C);
    chk("sw_stable", {31'b0, c_stable}, 32'h1);

`ifdef MEM_ALIGN_EXC_EN
    next_cyc();
    i_aluop    = EXE_LW_OP;
    i_mem_addr = 32'h101;
    i_wreg     = 1'b1;
    @(negedge clk);
    $display("txn LW_mis adel=%b req=%b stall=%b wreg=%b", o_excp_adel, dbus.req, o_stall_req, o_wreg);
    chk("adel", {31'b0, o_excp_adel}, 32'h1);
    chk("adel_req", {31'b0, dbus.req}, 32'h0);
    chk("adel_stall", {31'b0, o_stall_req}, 32'h0);
    chk("adel_wreg", {31'b0, o_wreg}, 32'h0);
    next_cyc();
    i_aluop    = EXE_SH_OP;
    i_mem_addr = 32'h203;
    @(negedge clk);
    $display("txn SH_mis ades=%b req=%b stall=%b", o_excp_ades, dbus.req, o_stall_req);
    chk("ades", {31'b0, o_excp_ades}, 32'h1);
    chk("ades_req", {31'b0, dbus.req}, 32'h0);
`else
    next_cyc();
    run_mem("LW_mis", EXE_LW_OP, 32'h101, 32'h0, 32'h13579BDF, 0);
    chk("lwmis_addr", c_addr, 32'h100);
    chk("lwmis_sel", {28'b0, c_sel}, 32'b1111);
    chk("lwmis_result", c_res, 32'h13579BDF);
`endif

    // Reset in the middle of a waiting load
    next_cyc();
    i_aluop    = EXE_LW_OP;
    i_mem_addr = 32'h400;
    i_wreg     = 1'b1;
    i_wd       = 5'd7;
    dbus.ack   = 1'b0;
    next_cyc();
    @(negedge clk);
    chk("busy_stall", {31'b0, o_stall_req}, 32'h1);
    rst = 1'b1;
    #1;
    $display("txn mid_reset req=%b stall=%b wdata=%h wreg=%b wd=%0d", dbus.req, o_stall_req, o_wdata, o_wreg, o_wd);
    chk("mrst_req", {31'b0, dbus.req}, 32'h0);
    chk("mrst_stall", {31'b0, o_stall_req}, 32'h0);
    chk("mrst_wdata", o_wdata, 32'h0);
    chk("mrst_wreg", {31'b0, o_wreg}, 32'h0);
    chk("mrst_wd", {27'b0, o_wd}, 32'h0);
    next_cyc();
    rst      = 1'b0;
    // An ack here would complete a stale access if the FSM had not returned to idle
    i_aluop  = ADD_OP;
    dbus.ack = 1'b1;
    next_cyc();
    dbus.ack = 1'b0;
    run_mem("LW_after_rst", EXE_LW_OP, 32'h400, 32'h0, 32'h2468ACE0, 1);
    chk("post_rst_stall", c_stall, 2);
    chk("post_rst_result", c_res, 32'h2468ACE0);
    chk("post_rst_addr", c_addr, 32'h400);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
